// File: rtl/ps2_command_tx.sv
// Host-to-device PS/2 command transmitter: inhibits the clock, issues a start bit,
// then shifts out one byte plus odd parity and stop on device clock falls.
// Optional build macro PS2_TX_ACK_CHECK_EN adds the ack_error output.
module ps2_command_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned START_TIMEOUT  = 750000,
    parameter int unsigned XFER_TIMEOUT   = 100000,
    parameter int unsigned CNT_W          = 20
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] command,
    input  logic       send_command,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_drive_low,
    output logic       ps2_dat_drive_low,
    output logic       busy,
    output logic       command_was_sent,
    output logic       error_communication_timed_out
`ifdef PS2_TX_ACK_CHECK_EN
    ,
    output logic       ack_error
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_DATA, S_ACK, S_WAIT_IDLE, S_DONE, S_ERR
    } state_t;

    localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;
    localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] XFER_LAST  = CNT_W'(XFER_TIMEOUT - 1);

    if (INHIBIT_CYCLES > CNT_MAX || START_TIMEOUT > CNT_MAX || XFER_TIMEOUT > CNT_MAX) begin : g_cnt_w_too_narrow
        $error("ps2_command_tx: CNT_W too narrow for the timing parameters");
    end

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic [3:0]       bit_idx, bit_idx_n;
    logic [9:0]       shift, shift_n;
    logic             dat_low, dat_low_n;
    logic             clk_s1, clk_s2, clk_prev, dat_s1, dat_s2;
    logic             fall;
`ifdef PS2_TX_ACK_CHECK_EN
    logic             ack_bad, ack_bad_n;
`endif

    assign fall    = clk_prev & ~clk_s2;
    assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shift    <= '1;
            dat_low  <= 1'b0;
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
`ifdef PS2_TX_ACK_CHECK_EN
            ack_bad  <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bit_idx  <= bit_idx_n;
            shift    <= shift_n;
            dat_low  <= dat_low_n;
            clk_s1   <= ps2_clk_in;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= ps2_dat_in;
            dat_s2   <= dat_s1;
`ifdef PS2_TX_ACK_CHECK_EN
            ack_bad  <= ack_bad_n;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        dat_low_n = dat_low;
`ifdef PS2_TX_ACK_CHECK_EN
        ack_bad_n = ack_bad;
`endif
        case (state)
            S_IDLE: begin
                dat_low_n = 1'b0;
                if (send_command) begin
                    shift_n   = {1'b1, ~^command, command};
                    bit_idx_n = '0;
                    cnt_n     = '0;
`ifdef PS2_TX_ACK_CHECK_EN
                    ack_bad_n = 1'b0;
`endif
                    state_n   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (cnt == INH_LAST) begin
                    dat_low_n = 1'b1;
                    cnt_n     = '0;
                    state_n   = S_REQ;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            S_REQ: begin
                if (fall) begin
                    dat_low_n = ~shift[0];
                    shift_n   = {1'b1, shift[9:1]};
                    bit_idx_n = 4'd1;
                    cnt_n     = '0;
                    state_n   = S_DATA;
                end else if (cnt >= START_LAST) begin
                    dat_low_n = 1'b0;
                    state_n   = S_ERR;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            // The transfer timeout spans DATA..WAIT_IDLE; a fall in the same cycle wins.
            S_DATA: begin
                cnt_n = cnt_inc;
                if (fall) begin
                    dat_low_n = ~shift[0];
                    shift_n   = {1'b1, shift[9:1]};
                    bit_idx_n = bit_idx + 4'd1;
                    if (bit_idx == 4'd9) state_n = S_ACK;
                end else if (cnt >= XFER_LAST) begin
                    dat_low_n = 1'b0;
                    state_n   = S_ERR;
                end
            end
            S_ACK: begin
                cnt_n     = cnt_inc;
                dat_low_n = 1'b0;
                if (fall) begin
`ifdef PS2_TX_ACK_CHECK_EN
                    ack_bad_n = dat_s2;
`endif
                    state_n = S_WAIT_IDLE;
                end else if (cnt >= XFER_LAST) begin
                    state_n = S_ERR;
                end
            end
            S_WAIT_IDLE: begin
                cnt_n = cnt_inc;
                if (clk_s2 && dat_s2)    state_n = S_DONE;
                else if (cnt >= XFER_LAST) state_n = S_ERR;
            end
            S_DONE: begin
                dat_low_n = 1'b0;
                state_n   = S_IDLE;
            end
            default: begin
                dat_low_n = 1'b0;
                state_n   = S_IDLE;
            end
        endcase
    end

    assign ps2_clk_drive_low             = (state == S_INHIBIT);
    assign ps2_dat_drive_low             = dat_low;
    assign busy                          = (state != S_IDLE);
    assign error_communication_timed_out = (state == S_ERR);
`ifdef PS2_TX_ACK_CHECK_EN
    assign command_was_sent = (state == S_DONE) && !ack_bad;
    assign ack_error        = (state == S_DONE) && ack_bad;
`else
    assign command_was_sent = (state == S_DONE);
`endif

endmodule

// File: tb/tb_ps2_command_tx.sv
// Self-checking bench for ps2_command_tx with a behavioural PS/2 device model.
module tb_ps2_command_tx;
    localparam int unsigned INH = 40;
    localparam int unsigned STO = 300;
    localparam int unsigned XTO = 1500;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] command = '0;
    logic       send_command = 1'b0;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    logic       ps2_clk_in, ps2_dat_in;
    logic       ps2_clk_drive_low, ps2_dat_drive_low, busy;
    logic       command_was_sent, error_communication_timed_out;
`ifdef PS2_TX_ACK_CHECK_EN
    logic       ack_error;
`endif

    assign ps2_clk_in = ~(ps2_clk_drive_low | dev_clk_low);
    assign ps2_dat_in = ~(ps2_dat_drive_low | dev_dat_low);

    ps2_command_tx #(
        .INHIBIT_CYCLES(INH),
        .START_TIMEOUT (STO),
        .XFER_TIMEOUT  (XTO),
        .CNT_W         (12)
    ) dut (
        .CLOCK_50                     (CLOCK_50),
        .reset                        (reset),
        .command                      (command),
        .send_command                 (send_command),
        .ps2_clk_in                   (ps2_clk_in),
        .ps2_dat_in                   (ps2_dat_in),
        .ps2_clk_drive_low            (ps2_clk_drive_low),
        .ps2_dat_drive_low            (ps2_dat_drive_low),
        .busy                         (busy),
        .command_was_sent             (command_was_sent),
        .error_communication_timed_out(error_communication_timed_out)
`ifdef PS2_TX_ACK_CHECK_EN
        ,
        .ack_error                    (ack_error)
`endif
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int unsigned cyc = 0, cws_n = 0, err_n = 0, ackerr_n = 0;
    always @(posedge CLOCK_50) begin
        cyc <= cyc + 1;
        if (command_was_sent) cws_n <= cws_n + 1;
        if (error_communication_timed_out) err_n <= err_n + 1;
`ifdef PS2_TX_ACK_CHECK_EN
        if (ack_error) ackerr_n <= ackerr_n + 1;
`endif
    end

    int checks = 0, errors = 0;

    task automatic tick;
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic ticks(input int unsigned n);
        repeat (n) tick;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected wire frame after the start bit: data LSB first, odd parity, stop.
    function automatic logic [9:0] frame_of(input logic [7:0] c);
        logic par;
        par = (($countones(c) % 2) == 0);
        return {1'b1, par, c};
    endfunction

    task automatic start_send(input logic [7:0] c, output int unsigned inh_len);
        command = c;
        send_command = 1'b1;
        tick;
        send_command = 1'b0;
        inh_len = 0;
        while (ps2_clk_drive_low && inh_len < INH + 100) begin
            inh_len++;
            tick;
        end
    endtask

    // Device clocking: high phase, fall, low phase, rise; line sampled on each rise.
    task automatic run_device(input int unsigned nclk, input int unsigned half, input bit ack_low,
                              output logic [9:0] bits, output int unsigned fall1_cyc);
        bits = '1;
        fall1_cyc = 0;
        for (int k = 1; k <= int'(nclk); k++) begin
            if (k == 11 && ack_low) begin
                ticks(half / 2);
                dev_dat_low = 1'b1;
                ticks(half - half / 2);
            end else begin
                ticks(half);
            end
            dev_clk_low = 1'b1;
            if (k == 1) fall1_cyc = cyc;
            ticks(half);
            dev_clk_low = 1'b0;
            if (k <= 10) bits[k-1] = ps2_dat_in;
            if (k == 11) begin
                tick;
                dev_dat_low = 1'b0;
            end
        end
    endtask

    task automatic full_send(input logic [7:0] c, input bit ack_low, input string tag);
        int unsigned inh, f1, c0, e0, a0;
        logic [9:0] bits;
        c0 = cws_n;
        e0 = err_n;
        a0 = ackerr_n;
        start_send(c, inh);
        chk({tag, " inhibit_len"}, inh, INH);
        chk({tag, " start_bit"}, 32'(ps2_dat_drive_low), 32'd1);
        run_device(11, $urandom_range(12, 25), ack_low, bits, f1);
        ticks(12);
        chk({tag, " frame"}, 32'(bits), 32'(frame_of(c)));
`ifdef PS2_TX_ACK_CHECK_EN
        chk({tag, " sent_pulses"}, cws_n - c0, ack_low ? 32'd1 : 32'd0);
        chk({tag, " ack_error_pulses"}, ackerr_n - a0, ack_low ? 32'd0 : 32'd1);
`else
        chk({tag, " sent_pulses"}, cws_n - c0, 32'd1);
        chk({tag, " ack_error_pulses"}, ackerr_n - a0, 32'd0);
`endif
        chk({tag, " timeout_pulses"}, err_n - e0, 32'd0);
        chk({tag, " busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned inh, n, f1, d;
        logic [9:0] bits;
        logic [7:0] c;

        // Reset state
        ticks(3);
        chk("reset_outputs",
            32'({ps2_clk_drive_low, ps2_dat_drive_low, busy, command_was_sent, error_communication_timed_out}),
            32'd0);
        reset = 1'b1;
        ticks(2);

        // Basic send and parity corners
        full_send(8'hED, 1'b1, "basic_ED");
        full_send(8'h00, 1'b1, "parity_00");
        full_send(8'hFF, 1'b1, "parity_FF");
        for (int i = 0; i < 3; i++) full_send(8'($urandom), 1'b1, "random");

        // No device response after the start bit
        start_send(8'($urandom), inh);
        chk("noresp inhibit_len", inh, INH);
        n = 0;
        while (!error_communication_timed_out && n < STO + 50) begin
            tick;
            n++;
        end
        chk("noresp timeout_cycles", n, STO);
        chk("noresp lines_released", 32'({ps2_clk_drive_low, ps2_dat_drive_low}), 32'd0);
        tick;
        chk("noresp busy_after", 32'(busy), 32'd0);

        // Device stalls after data bit 4
        c = 8'($urandom);
        start_send(c, inh);
        run_device(5, $urandom_range(12, 25), 1'b0, bits, f1);
        chk("stall first_bits", 32'(bits[4:0]), 32'(c[4:0]));
        n = 0;
        while (!error_communication_timed_out && n < XTO + 200) begin
            tick;
            n++;
        end
        d = cyc - f1;
        // Timeout counts from the synchronized fall, 2-3 cycles after the pin edge.
        chk("stall timeout_window", 32'(d >= XTO + 2 && d <= XTO + 3), 32'd1);
        chk("stall dat_released", 32'(ps2_dat_drive_low), 32'd0);
        tick;
        chk("stall busy_after", 32'(busy), 32'd0);

        // Asynchronous reset while data bit 3 (a zero) is driven
        c = 8'($urandom) & 8'hF7;
        start_send(c, inh);
        run_device(4, $urandom_range(12, 25), 1'b0, bits, f1);
        chk("rst bit3_driven", 32'(ps2_dat_drive_low), 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("rst async_release", 32'({ps2_clk_drive_low, ps2_dat_drive_low, busy}), 32'd0);
        ticks(2);
        reset = 1'b1;
        ticks(3);
        full_send(8'($urandom), 1'b1, "after_reset");

        // Device leaves data high during the acknowledge clock
        full_send(8'($urandom), 1'b0, "no_ack");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
